// File: rtl/button_conditioner.sv
// Push-button front end: per key, a two-flop synchronizer, a debounce filter and a
// small FSM that emits one-cycle press/release pulses plus optional auto-repeat.
module button_conditioner #(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] btn_n,
    input  logic [N_BUTTONS-1:0] repeat_en,
    output logic [N_BUTTONS-1:0] level,
    output logic [N_BUTTONS-1:0] press,
    output logic [N_BUTTONS-1:0] release_pulse
);

    localparam int HC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HC_W   = $clog2(HC_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0] DELAY_LAST  = HC_W'(REPEAT_DELAY - 1);
    localparam logic [HC_W-1:0] PERIOD_LAST = HC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_REPEATING = 2'd2
    } state_t;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        logic            sync_meta;
        logic            sync_s;
        logic [DB_W-1:0] db_cnt;
        logic [DB_W-1:0] db_cnt_nxt;
        logic            accept;
        state_t          state;
        state_t          state_nxt;
        logic [HC_W-1:0] hc;
        logic [HC_W-1:0] hc_nxt;
        logic            level_q;
        logic            level_nxt;
        logic            press_q;
        logic            press_nxt;
        logic            rel_q;
        logic            rel_nxt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_meta <= 1'b0;
                sync_s    <= 1'b0;
                db_cnt    <= '0;
                state     <= ST_RELEASED;
                hc        <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                rel_q     <= 1'b0;
            end else begin
                sync_meta <= ~btn_n[i];
                sync_s    <= sync_meta;
                db_cnt    <= db_cnt_nxt;
                state     <= state_nxt;
                hc        <= hc_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                rel_q     <= rel_nxt;
            end
        end

        // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            db_cnt_nxt = '0;
            accept     = 1'b0;
            if (sync_s != level_q) begin
                if (db_cnt == DB_LAST) begin
                    accept = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
        end

        always_comb begin
            state_nxt = state;
            hc_nxt    = hc;
            level_nxt = level_q;
            press_nxt = 1'b0;
            rel_nxt   = 1'b0;
            case (state)
                ST_RELEASED: begin
                    hc_nxt = '0;
                    if (accept) begin
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                        state_nxt = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (accept) begin
                        level_nxt = 1'b0;
                        rel_nxt   = 1'b1;
                        hc_nxt    = '0;
                        state_nxt = ST_RELEASED;
                    end else if (repeat_en[i]) begin
                        if (hc == DELAY_LAST) begin
                            press_nxt = 1'b1;
                            hc_nxt    = '0;
                            state_nxt = ST_REPEATING;
                        end else begin
                            hc_nxt = hc + 1'b1;
                        end
                    end else begin
                        hc_nxt = '0;
                    end
                end
                ST_REPEATING: begin
                    // Release wins over a repeat pulse falling due on the same edge.
                    if (accept) begin
                        level_nxt = 1'b0;
                        rel_nxt   = 1'b1;
                        hc_nxt    = '0;
                        state_nxt = ST_RELEASED;
                    end else if (repeat_en[i]) begin
                        if (hc == PERIOD_LAST) begin
                            press_nxt = 1'b1;
                            hc_nxt    = '0;
                        end else begin
                            hc_nxt = hc + 1'b1;
                        end
                    end else begin
                        hc_nxt    = '0;
                        state_nxt = ST_PRESSED;
                    end
                end
                default: begin
                    hc_nxt    = '0;
                    level_nxt = 1'b0;
                    state_nxt = ST_RELEASED;
                end
            endcase
        end

        assign level[i]         = level_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: each scenario queues the pulses it expects
// (edge number, channel, kind) and the per-cycle monitor pops and compares them.
module tb_button_conditioner;

    localparam int N   = 3;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = DB + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] btn_n = '1;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        int at;
        int ch;
        bit is_rel;
    } exp_t;

    exp_t sb[$];

    button_conditioner #(
        .N_BUTTONS(N),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_n(btn_n),
        .repeat_en(repeat_en),
        .level(level),
        .press(press),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic expect_pulse(input int at, input int ch, input bit is_rel);
        exp_t e;
        e.at = at;
        e.ch = ch;
        e.is_rel = is_rel;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare every observed pulse against the head of the scoreboard.
    task automatic step();
        exp_t e;
        logic obs;
        @(posedge clk);
        edge_n++;
        #1;
        for (int c = 0; c < N; c++) begin
            checks++;
            if (press[c] === 1'b1 && release_pulse[c] === 1'b1) begin
                errors++;
                $display("[TB] FAIL both_high ch%0d edge %0d: press and release both 1, required not both", c, edge_n);
            end
            for (int k = 0; k < 2; k++) begin
                obs = (k == 1) ? release_pulse[c] : press[c];
                if (obs !== 1'b0) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_pulse ch%0d kind %0d edge %0d: got %b, required 0", c, k, edge_n, obs);
                    end else begin
                        e = sb.pop_front();
                        if (e.at !== edge_n || e.ch !== c || e.is_rel !== bit'(k)) begin
                            errors++;
                            $display("[TB] FAIL pulse: got ch%0d kind %0d at edge %0d, required ch%0d kind %0d at edge %0d",
                                     c, k, edge_n, e.ch, e.is_rel, e.at);
                        end
                    end
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (level !== '0) begin errors++; $display("[TB] FAIL reset_level: got %b, required 000", level); end
        checks++;
        if (press !== '0) begin errors++; $display("[TB] FAIL reset_press: got %b, required 000", press); end
        checks++;
        if (release_pulse !== '0) begin errors++; $display("[TB] FAIL reset_release: got %b, required 000", release_pulse); end
        run(2);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({level, press, release_pulse} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_idle edge %0d: got %b/%b/%b, required all 0", edge_n, level, press, release_pulse);
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL reset_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_clean_press();
        int t0;
        int t1;
        logic exp_lvl;
        $display("[TB] test_clean_press");
        run(2);
        t0 = edge_n;
        btn_n[0] = 1'b0;
        expect_pulse(t0 + LAT, 0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step();
            exp_lvl = (edge_n >= t0 + LAT);
            checks++;
            if (level !== {2'b00, exp_lvl}) begin
                errors++;
                $display("[TB] FAIL clean_level_hi edge %0d: got %b, required %b", edge_n, level, {2'b00, exp_lvl});
            end
        end
        t1 = edge_n;
        btn_n[0] = 1'b1;
        expect_pulse(t1 + LAT, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            exp_lvl = (edge_n < t1 + LAT);
            checks++;
            if (level !== {2'b00, exp_lvl}) begin
                errors++;
                $display("[TB] FAIL clean_level_lo edge %0d: got %b, required %b", edge_n, level, {2'b00, exp_lvl});
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL clean_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_bounce();
        int t1;
        $display("[TB] test_bounce");
        for (int i = 0; i < 10; i++) begin
            btn_n[1] = (i % 2 == 1);
            run(2);
            checks++;
            if (level[1] !== 1'b0) begin errors++; $display("[TB] FAIL bounce_level edge %0d: got %b, required 0", edge_n, level[1]); end
        end
        t1 = edge_n;
        btn_n[1] = 1'b0;
        expect_pulse(t1 + LAT, 1, 1'b0);
        run(LAT + 9);
        checks++;
        if (level[1] !== 1'b1) begin errors++; $display("[TB] FAIL bounce_accept: got %b, required 1", level[1]); end
        t1 = edge_n;
        btn_n[1] = 1'b1;
        expect_pulse(t1 + LAT, 1, 1'b1);
        run(LAT + 4);
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL bounce_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_auto_repeat();
        int t0;
        int p;
        int rel;
        int drop;
        $display("[TB] test_auto_repeat");
        repeat_en[2] = 1'b1;
        t0 = edge_n;
        btn_n[2] = 1'b0;
        p = t0 + LAT;
        rel = p + 20 + LAT;
        expect_pulse(p, 2, 1'b0);
        for (int e = p + RD; e < rel; e += RP) expect_pulse(e, 2, 1'b0);
        expect_pulse(rel, 2, 1'b1);
        run(LAT + 20);
        btn_n[2] = 1'b1;
        run(LAT + 4);
        checks++;
        if (level[2] !== 1'b0) begin errors++; $display("[TB] FAIL repeat_release_level: got %b, required 0", level[2]); end

        // Second hold: repeat_en drops mid-train, pulses stop while the key stays down.
        t0 = edge_n;
        btn_n[2] = 1'b0;
        p = t0 + LAT;
        drop = p + 14;
        expect_pulse(p, 2, 1'b0);
        for (int e = p + RD; e <= drop; e += RP) expect_pulse(e, 2, 1'b0);
        run(LAT + 14);
        repeat_en[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (level[2] !== 1'b1) begin errors++; $display("[TB] FAIL repeat_drop_level edge %0d: got %b, required 1", edge_n, level[2]); end
        end
        t0 = edge_n;
        btn_n[2] = 1'b1;
        expect_pulse(t0 + LAT, 2, 1'b1);
        run(LAT + 4);
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL repeat_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_concurrent();
        int t0;
        $display("[TB] test_concurrent");
        repeat_en = '0;
        t0 = edge_n;
        btn_n[1:0] = 2'b00;
        expect_pulse(t0 + LAT, 0, 1'b0);
        expect_pulse(t0 + LAT, 1, 1'b0);
        run(50);
        checks++;
        if (level !== 3'b011) begin errors++; $display("[TB] FAIL concurrent_level: got %b, required 011", level); end
        t0 = edge_n;
        btn_n = '1;
        expect_pulse(t0 + LAT, 0, 1'b1);
        expect_pulse(t0 + LAT, 1, 1'b1);
        run(LAT + 4);
        checks++;
        if (level !== 3'b000) begin errors++; $display("[TB] FAIL concurrent_release_level: got %b, required 000", level); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL concurrent_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_during_hold();
        int t0;
        int p;
        int r;
        $display("[TB] test_reset_during_hold");
        repeat_en[0] = 1'b1;
        t0 = edge_n;
        btn_n[0] = 1'b0;
        p = t0 + LAT;
        expect_pulse(p, 0, 1'b0);
        expect_pulse(p + RD, 0, 1'b0);
        run(LAT + 12);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({level, press, release_pulse} !== '0) begin
            errors++;
            $display("[TB] FAIL hold_reset_async: got %b/%b/%b, required all 0", level, press, release_pulse);
        end
        run(2);
        reset = 1'b0;
        r = edge_n;
        expect_pulse(r + LAT, 0, 1'b0);
        expect_pulse(r + LAT + RD, 0, 1'b0);
        expect_pulse(r + LAT + RD + RP, 0, 1'b0);
        run(LAT + RD + RP + 1);
        t0 = edge_n;
        btn_n[0] = 1'b1;
        repeat_en = '0;
        expect_pulse(t0 + LAT, 0, 1'b1);
        run(LAT + 4);
        checks++;
        if (level !== 3'b000) begin errors++; $display("[TB] FAIL hold_final_level: got %b, required 000", level); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL hold_pending: got %0d, required 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_concurrent();
        test_reset_during_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for the clock's push buttons. Takes raw, bouncing, active-low key inputs and runs each one through a two-flop synchronizer and a debounce filter. Each key produces a clean level plus single-cycle press and release pulses, with optional auto-repeat while held. It sits directly upstream of the clock/time-setting logic, so that block only sees one pulse per physical press, or a steady pulse train when a set key is held.

## Interface

Parameters:
- N_BUTTONS, 3: number of independent key channels.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a level change (5 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles from accepted press to first auto-repeat pulse (500 ms).
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses (100 ms).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- btn_n  in  N_BUTTONS  raw key inputs, active-low (0 = pressed), asynchronous to clk.
- repeat_en  in  N_BUTTONS  per-key auto-repeat enable, synchronous to clk.
- level  out  N_BUTTONS  debounced key state, active-high (1 = pressed).
- press  out  N_BUTTONS  one-cycle pulse on accepted press and on each auto-repeat.
- release  out  N_BUTTONS  one-cycle pulse on accepted release.

## Operation

- All channels are identical and fully independent. Simultaneous activity on several keys is handled per channel with no interaction.
- Synchronizer: two flops sample ~btn_n. The synchronized value s is inverted to active-high.
- Debounce:
  - The counter clears whenever s == level.
  - It increments while s != level.
  - When the counter is at DEBOUNCE_CYCLES-1 and s != level, level toggles on the next edge and the counter clears.
  - Any glitch back to s == level before that point discards the partial count.
- Per-channel FSM (2 bits), with hold counter hc wide enough for max(REPEAT_DELAY, REPEAT_PERIOD):
  - RELEASED: level 0.
    - On accept-press: level goes to 1, press pulses, hc = 0, next state PRESSED.
  - PRESSED:
    - On accept-release: level goes to 0, release pulses, next state RELEASED.
    - Else if repeat_en: hc increments. At hc == REPEAT_DELAY-1, press pulses, hc = 0, next state REPEATING.
    - Else: hc held at 0.
  - REPEATING:
    - On accept-release: release pulses, next state RELEASED.
    - Else if repeat_en: hc increments. At hc == REPEAT_PERIOD-1, press pulses and hc = 0.
    - Else if repeat_en is low: hc = 0, next state PRESSED. No pulse.
- Release takes priority over any repeat pulse due in the same cycle. press and release are never high together on one channel.
- Reset: all sync flops, debounce counters, hc and level clear to 0, FSM goes to RELEASED, press and release go to 0. A key already held when reset deasserts is accepted as a fresh press after the normal latency.

## Timing

- Reset values: level = 0, press = 0, release = 0 on all channels. Outputs clear immediately on reset assertion (asynchronous).
- All outputs are registered. There is no combinational path from btn_n or repeat_en to the outputs.
- Press latency: btn_n falls and stays low from edge k. Then level rises and press pulses at edge k + 2 + DEBOUNCE_CYCLES. Release latency is symmetric.
- Auto-repeat with repeat_en held high: pulses at P, P + REPEAT_DELAY, then every REPEAT_PERIOD cycles, where P is the accepted-press edge.
- A repeat_en change takes effect on the edge after it is sampled.
- Every pulse is exactly one clk cycle wide.
- Minimum legal parameter values: DEBOUNCE_CYCLES ≥ 1, REPEAT_DELAY ≥ 2, REPEAT_PERIOD ≥ 2.

## Test plan

Parameters for simulation: N_BUTTONS = 3, DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3.

- Reset: assert reset mid-cycle with btn_n = 3'b111 -> level, press and release are 0 immediately and remain 0 for 20 cycles after release.
- Clean press and release: btn_n[0] = 0 at edge 10, back to 1 at edge 40 -> press[0] high only at edge 16 and level[0] high over edges 16–45. release[0] high only at edge 46. Channels 1 and 2 stay 0.
- Bounce rejection: toggle btn_n[1] every 2 cycles for 20 cycles, then hold it low -> no press[1] during bouncing, then exactly one press[1] 6 cycles after the final stable low.
- Auto-repeat: repeat_en[2] = 1, hold btn_n[2] low -> press[2] at P, P+10, P+13, P+16, …. On release, release[2] pulses once and press[2] stops. Dropping repeat_en[2] mid-train stops pulses without a release pulse.
- No repeat and concurrent keys: repeat_en = 0, press keys 0 and 1 together and hold for 50 cycles -> exactly one press on each channel, in the same cycle.
- Reset during hold: key 0 is in REPEATING, then reset is pulsed while btn_n[0] stays low -> all outputs 0 at once. After deassertion, press[0] fires at reset-release edge + 6 and the repeat schedule restarts from REPEAT_DELAY.
